// File: rtl/uart_term_pkg.sv
// uart_term_pkg: shared types and constants for the uart_term_rx serial receiver.
// MIN_PRESCALE tracks UART_TERM_RX_MAJORITY_EN (majority voting needs wider bits).
package uart_term_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   typedef struct packed {
      logic       perr;
      logic       ferr;
      logic [7:0] data;
   } entry_t;

`ifdef UART_TERM_RX_MAJORITY_EN
   localparam int MIN_PRESCALE = 8;
`else
   localparam int MIN_PRESCALE = 4;
`endif

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_term_fifo.sv
// uart_term_fifo: first-word-fall-through synchronous FIFO, power-of-two depth.
// Head reads as zero while empty; a push into a full FIFO is discarded.
module uart_term_fifo #(
   parameter int W     = 10,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   level
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   cnt;
   logic          wr_ok, rd_ok;

   assign empty = (cnt == '0);
   assign full  = (cnt == (AW+1)'(DEPTH));
   assign level = cnt;
   assign wr_ok = push & ~full;
   assign rd_ok = pop & ~empty;
   assign rdata = empty ? '0 : mem[rp];

   always_ff @(posedge HCLK) begin
      if (wr_ok) mem[wp] <= wdata;
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (wr_ok) wp <= wp + 1'b1;
         if (rd_ok) rp <= rp + 1'b1;
         unique case ({wr_ok, rd_ok})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/uart_term_rx.sv
// uart_term_rx: mid-bit sampling UART receiver with error flags and FWFT FIFO.
// Define UART_TERM_RX_MAJORITY_EN for 2-of-3 majority bit decisions.
module uart_term_rx
   import uart_term_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 8,
   parameter int PRESCALE_W = 16
) (
   input  logic                        HCLK,
   input  logic                        HRESETn,
   input  logic                        rx,
   input  logic [PRESCALE_W-1:0]       prescale,
   input  logic                        parity_en,
   input  logic                        parity_odd,
   input  logic                        rd,
   input  logic                        clr_ovr,
   output logic [DATA_BITS-1:0]        rdata,
   output logic                        rperr,
   output logic                        rferr,
   output logic                        rvalid,
   output logic [$clog2(FIFO_DEPTH):0] level,
   output logic                        overrun,
   output logic                        busy
);

   state_t                state, state_n;
   logic [PRESCALE_W-1:0] cnt, cnt_n, ps, half;
   logic [2:0]            idx, idx_n;
   logic [DATA_BITS-1:0]  sh, sh_n;
   logic                  perr, perr_n, ferr, ferr_n;
   logic                  s1, s2, h1;
   logic                  tick, smp, fall, push, full, empty;
   entry_t                wentry, hentry;

   assign ps   = (prescale < PRESCALE_W'(MIN_PRESCALE))
               ? PRESCALE_W'(MIN_PRESCALE) : prescale;
   assign tick = (cnt <= PRESCALE_W'(1));
   assign fall = h1 & ~s2;

`ifdef UART_TERM_RX_MAJORITY_EN
   logic h2;
   // Decision lands one cycle late so the vote window centres on mid-bit.
   assign half = (ps >> 1) + 1'b1;
   assign smp  = maj3(s2, h1, h2);
   always_ff @(posedge HCLK) begin
      if (!HRESETn) h2 <= 1'b1;
      else          h2 <= h1;
   end
`else
   assign half = ps >> 1;
   assign smp  = s2;
`endif

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      sh_n    = sh;
      perr_n  = perr;
      ferr_n  = ferr;
      push    = 1'b0;
      if (state != IDLE) cnt_n = tick ? ps : cnt - 1'b1;
      unique case (state)
         IDLE: begin
            if (fall) begin
               state_n = START;
               cnt_n   = half;
               idx_n   = '0;
               perr_n  = 1'b0;
               ferr_n  = 1'b0;
            end
         end
         START: begin
            if (tick) state_n = smp ? IDLE : DATA;
         end
         DATA: begin
            if (tick) begin
               sh_n = {smp, sh[DATA_BITS-1:1]};
               if (idx == 3'(DATA_BITS-1)) begin
                  idx_n   = '0;
                  state_n = parity_en ? PARITY : STOP;
               end else begin
                  idx_n = idx + 1'b1;
               end
            end
         end
         PARITY: begin
            if (tick) begin
               perr_n  = ((^sh) ^ smp) != parity_odd;
               state_n = STOP;
            end
         end
         STOP: begin
            if (tick) begin
               ferr_n = ferr | ~smp;
               if (idx == 3'(STOP_BITS-1)) begin
                  push    = 1'b1;
                  state_n = IDLE;
               end else begin
                  idx_n = idx + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      wentry      = '0;
      wentry.perr = perr;
      wentry.ferr = ferr_n;
      wentry.data = 8'(sh);
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         s1      <= 1'b1;
         s2      <= 1'b1;
         h1      <= 1'b1;
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         sh      <= '0;
         perr    <= 1'b0;
         ferr    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         s1    <= rx;
         s2    <= s1;
         h1    <= s2;
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         sh    <= sh_n;
         perr  <= perr_n;
         ferr  <= ferr_n;
         if (push & full) overrun <= 1'b1;
         else if (clr_ovr) overrun <= 1'b0;
      end
   end

   uart_term_fifo #(
      .W     ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .push    (push),
      .wdata   (wentry),
      .pop     (rd),
      .rdata   (hentry),
      .empty   (empty),
      .full    (full),
      .level   (level)
   );

   assign rdata  = hentry.data[DATA_BITS-1:0];
   assign rperr  = hentry.perr;
   assign rferr  = hentry.ferr;
   assign rvalid = ~empty;
   assign busy   = (state != IDLE);

endmodule

// File: tb/tb_uart_term_rx.sv
// tb_uart_term_rx: scoreboard bench for uart_term_rx (1 and 2 stop-bit builds).
// Frames are driven on the falling edge; outputs are sampled on the falling edge.
module tb_uart_term_rx;

   logic        HCLK = 1'b0;
   logic        HRESETn, rx, rx2, parity_en, parity_odd;
   logic        rd, rd2, clr_ovr;
   logic [15:0] prescale;
   logic [7:0]  rdata, rdata2;
   logic        rperr, rferr, rvalid, overrun, busy;
   logic        rperr2, rferr2, rvalid2, overrun2, busy2;
   logic [3:0]  level, level2;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [9:0]  q[$];
   logic [9:0]  q2[$];
   logic        exp_ovr = 1'b0;

   always #5 HCLK = ~HCLK;

   uart_term_rx dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .rx(rx), .prescale(prescale),
      .parity_en(parity_en), .parity_odd(parity_odd), .rd(rd),
      .clr_ovr(clr_ovr), .rdata(rdata), .rperr(rperr), .rferr(rferr),
      .rvalid(rvalid), .level(level), .overrun(overrun), .busy(busy)
   );

   uart_term_rx #(.STOP_BITS(2)) dut2 (
      .HCLK(HCLK), .HRESETn(HRESETn), .rx(rx2), .prescale(prescale),
      .parity_en(parity_en), .parity_odd(parity_odd), .rd(rd2),
      .clr_ovr(clr_ovr), .rdata(rdata2), .rperr(rperr2), .rferr(rferr2),
      .rvalid(rvalid2), .level(level2), .overrun(overrun2), .busy(busy2)
   );

   task automatic send_bits(input bit tgt, input logic [15:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         if (tgt) rx2 = b[i];
         else     rx  = b[i];
         repeat (prescale) @(negedge HCLK);
      end
      if (tgt) rx2 = 1'b1;
      else     rx  = 1'b1;
   endtask

   task automatic send_char(input bit tgt, input logic [7:0] d, input bit pbit,
                            input logic [1:0] stp, input int nstop);
      logic [15:0] b;
      int          n;
      logic        pe, fe;
      b    = '1;
      b[0] = 1'b0;
      for (int i = 0; i < 8; i++) b[1+i] = d[i];
      n  = 9;
      pe = 1'b0;
      if (parity_en) begin
         b[n] = pbit;
         n    = n + 1;
         pe   = ((^d) ^ pbit) != parity_odd;
      end
      fe = 1'b0;
      for (int i = 0; i < nstop; i++) begin
         b[n] = stp[i];
         n    = n + 1;
         fe   = fe | ~stp[i];
      end
      if (tgt)              q2.push_back({pe, fe, d});
      else if (q.size() < 8) q.push_back({pe, fe, d});
      else                  exp_ovr = 1'b1;
      send_bits(tgt, b, n);
      repeat (prescale) @(negedge HCLK);
   endtask

   task automatic drain(input bit tgt, input string nm);
      logic [9:0] e, got;
      logic       v;
      int         t;
      while ((tgt ? q2.size() : q.size()) > 0) begin
         e = tgt ? q2.pop_front() : q.pop_front();
         t = 0;
         v = tgt ? rvalid2 : rvalid;
         while (!v && t < 400) begin
            @(negedge HCLK);
            t++;
            v = tgt ? rvalid2 : rvalid;
         end
         got = tgt ? {rperr2, rferr2, rdata2} : {rperr, rferr, rdata};
         n_cmp++;
         if (!v || got !== e) begin
            n_bad++;
            $display("FAIL %s: rvalid=%b {perr,ferr,data}=%h required %h",
                     nm, v, got, e);
         end
         if (tgt) rd2 = 1'b1;
         else     rd  = 1'b1;
         @(negedge HCLK);
         rd  = 1'b0;
         rd2 = 1'b0;
      end
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      repeat (3) @(negedge HCLK);
      HRESETn = 1'b1;
      @(negedge HCLK);
      n_cmp++;
      if ({rvalid, level, overrun, busy} !== 7'd0) begin
         n_bad++;
         $display("FAIL reset_flags: {rvalid,level,ovr,busy}=%b required 0",
                  {rvalid, level, overrun, busy});
      end
      n_cmp++;
      if ({rperr, rferr, rdata} !== 10'd0) begin
         n_bad++;
         $display("FAIL reset_head: %h required 000", {rperr, rferr, rdata});
      end
      n_cmp++;
      if ({rvalid2, level2, busy2} !== 6'd0) begin
         n_bad++;
         $display("FAIL reset_dut2: %b required 0", {rvalid2, level2, busy2});
      end
   endtask

   task automatic test_basic();
      send_char(0, 8'h55, 1'b0, 2'b11, 1);
      send_char(0, 8'hA3, 1'b0, 2'b11, 1);
      n_cmp++;
      if (level !== 4'(q.size())) begin
         n_bad++;
         $display("FAIL basic_level: %0d required %0d", level, q.size());
      end
      drain(0, "basic_char");
      n_cmp++;
      if (level !== 4'd0 || rvalid !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_empty: level=%0d rvalid=%b required 0/0",
                  level, rvalid);
      end
   endtask

   task automatic test_parity();
      parity_en  = 1'b1;
      parity_odd = 1'b0;
      send_char(0, 8'h07, 1'b0, 2'b11, 1);
      send_char(0, 8'h07, 1'b1, 2'b11, 1);
      parity_odd = 1'b1;
      send_char(0, 8'h07, 1'b0, 2'b11, 1);
      send_char(0, 8'hC3, 1'b0, 2'b11, 1);
      drain(0, "parity");
      parity_en  = 1'b0;
      parity_odd = 1'b0;
   endtask

   task automatic test_framing();
      send_char(0, 8'h41, 1'b0, 2'b00, 1);
      send_char(0, 8'h41, 1'b0, 2'b11, 1);
      drain(0, "framing");
   endtask

   task automatic test_stop2();
      send_char(1, 8'h41, 1'b0, 2'b01, 2);
      send_char(1, 8'h5A, 1'b0, 2'b11, 2);
      send_char(1, 8'h41, 1'b0, 2'b10, 2);
      drain(1, "stop2");
   endtask

   task automatic test_glitch();
      rx = 1'b0;
      repeat (4) @(negedge HCLK);
      rx = 1'b1;
      repeat (2) @(negedge HCLK);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL glitch_busy: %b required 1", busy);
      end
      repeat (30) @(negedge HCLK);
      n_cmp++;
      if ({busy, rvalid, level} !== 6'd0) begin
         n_bad++;
         $display("FAIL glitch_idle: {busy,rvalid,level}=%b required 0",
                  {busy, rvalid, level});
      end
   endtask

   task automatic test_back_to_back();
      exp_ovr = 1'b0;
      for (int i = 0; i < 9; i++) send_char(0, 8'h10 + 8'(i * 7), 1'b0, 2'b11, 1);
      n_cmp++;
      if (level !== 4'(q.size())) begin
         n_bad++;
         $display("FAIL ovr_level: %0d required %0d", level, q.size());
      end
      n_cmp++;
      if (overrun !== exp_ovr) begin
         n_bad++;
         $display("FAIL ovr_flag: %b required %b", overrun, exp_ovr);
      end
      clr_ovr = 1'b1;
      @(negedge HCLK);
      clr_ovr = 1'b0;
      n_cmp++;
      if (overrun !== 1'b0) begin
         n_bad++;
         $display("FAIL ovr_clear: %b required 0", overrun);
      end
      drain(0, "ovr_char");
      @(negedge HCLK);
      n_cmp++;
      if (rvalid !== 1'b0 || level !== 4'd0) begin
         n_bad++;
         $display("FAIL ovr_drop: rvalid=%b level=%0d required 0/0",
                  rvalid, level);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0]  d;
      logic [15:0] b;
      d = 8'h3C;
      b = {7'h7f, d, 1'b0};
      send_bits(0, b, 4);
      rx = d[3];
      repeat (8) @(negedge HCLK);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_busy_before: %b required 1", busy);
      end
      HRESETn = 1'b0;
      @(negedge HCLK);
      HRESETn = 1'b1;
      rx      = 1'b1;
      @(negedge HCLK);
      n_cmp++;
      if ({busy, level} !== 5'd0) begin
         n_bad++;
         $display("FAIL mid_reset: {busy,level}=%b required 0", {busy, level});
      end
      repeat (200) @(negedge HCLK);
      n_cmp++;
      if (level !== 4'd0) begin
         n_bad++;
         $display("FAIL mid_nopush: level=%0d required 0", level);
      end
      send_char(0, d, 1'b0, 2'b11, 1);
      drain(0, "mid_next");
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      HRESETn    = 1'b0;
      rx         = 1'b1;
      rx2        = 1'b1;
      prescale   = 16'd16;
      parity_en  = 1'b0;
      parity_odd = 1'b0;
      rd         = 1'b0;
      rd2        = 1'b0;
      clr_ovr    = 1'b0;
      test_reset();
      test_basic();
      test_parity();
      test_framing();
      test_stop2();
      test_glitch();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
